// File: rtl/timer_counter_core.sv
// Counting engine of the 8-bit timer: pclk prescaler (/2../16) feeding a loadable up/down counter
// with one-cycle overflow/underflow pulses. Optional debug halt via the TIMER_HALT_EN macro.
module timer_counter_core #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PRE_W = 4
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             load,
  input  logic [CNT_W-1:0] tdr,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       cks,
`ifdef TIMER_HALT_EN
  input  logic             dbg_halt,
`endif
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             ovf_pulse,
  output logic             udf_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MIN = '0;

  logic [PRE_W-1:0] pre, pre_nxt;
  logic [1:0]       cks_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             tick_nxt, ovf_nxt, udf_nxt;
  logic [PRE_W-1:0] pre_last_c;
  logic             cks_chg_c;
  logic             halt_c;
  logic             tick_c;

`ifdef TIMER_HALT_EN
  assign halt_c = dbg_halt;
`else
  assign halt_c = 1'b0;
`endif

  // Terminal prescaler value is N-1 with N = 2 << cks.
  assign pre_last_c = PRE_W'((32'd2 << cks) - 32'd1);
  assign cks_chg_c  = (cks != cks_q);
  assign tick_c     = en && !cks_chg_c && !halt_c && (pre == pre_last_c);

  // Next-state for prescaler, counter and pulses; load wins over a same-cycle tick.
  always_comb begin
    pre_nxt  = pre;
    cnt_nxt  = cnt;
    tick_nxt = 1'b0;
    ovf_nxt  = 1'b0;
    udf_nxt  = 1'b0;
    if (load) begin
      pre_nxt = '0;
      cnt_nxt = tdr;
    end else begin
      if (!en || cks_chg_c) begin
        pre_nxt = '0;
      end else if (halt_c) begin
        pre_nxt = pre;
      end else if (tick_c) begin
        pre_nxt = '0;
      end else begin
        pre_nxt = pre + PRE_W'(1);
      end
      if (tick_c) begin
        tick_nxt = 1'b1;
        if (!up_dn) begin
          cnt_nxt = cnt + CNT_W'(1);
          ovf_nxt = (cnt == CNT_MAX);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          udf_nxt = (cnt == CNT_MIN);
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pre       <= '0;
      cks_q     <= 2'b00;
      cnt       <= '0;
      tick      <= 1'b0;
      ovf_pulse <= 1'b0;
      udf_pulse <= 1'b0;
    end else begin
      pre       <= pre_nxt;
      cks_q     <= cks;
      cnt       <= cnt_nxt;
      tick      <= tick_nxt;
      ovf_pulse <= ovf_nxt;
      udf_pulse <= udf_nxt;
    end
  end

endmodule

// File: tb/tb_timer_counter_core.sv
// Bench for timer_counter_core: cycle-level reference model compared every cycle, plus directed
// scenarios with hand-computed values. Halt scenario runs only when TIMER_HALT_EN is defined.
module tb_timer_counter_core;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       load;
  logic [7:0] tdr;
  logic       en;
  logic       up_dn;
  logic [1:0] cks;
  logic       dbg_halt;
  logic [7:0] cnt;
  logic       tick;
  logic       ovf_pulse;
  logic       udf_pulse;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  timer_counter_core dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .load      (load),
    .tdr       (tdr),
    .en        (en),
    .up_dn     (up_dn),
    .cks       (cks),
`ifdef TIMER_HALT_EN
    .dbg_halt  (dbg_halt),
`endif
    .cnt       (cnt),
    .tick      (tick),
    .ovf_pulse (ovf_pulse),
    .udf_pulse (udf_pulse)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks elapsed enabled cycles in the current period and the active divisor.
  function automatic int divisor(input logic [1:0] c);
    return 2 ** (int'(c) + 1);
  endfunction

  int m_cnt, m_phase, m_div;
  bit exp_tick, exp_ovf, exp_udf;
  bit m_halted, m_restart, m_fire;

`ifdef TIMER_HALT_EN
  assign m_halted = dbg_halt;
`else
  assign m_halted = 1'b0;
`endif
  assign m_restart = (divisor(cks) != m_div);
  assign m_fire    = en && !m_restart && !m_halted && (m_phase + 1 == divisor(cks));

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      m_cnt    <= 0;
      m_phase  <= 0;
      m_div    <= 2;
      exp_tick <= 1'b0;
      exp_ovf  <= 1'b0;
      exp_udf  <= 1'b0;
    end else begin
      m_div <= divisor(cks);
      if (load) begin
        m_cnt    <= int'(tdr);
        m_phase  <= 0;
        exp_tick <= 1'b0;
        exp_ovf  <= 1'b0;
        exp_udf  <= 1'b0;
      end else begin
        exp_tick <= m_fire;
        exp_ovf  <= m_fire && !up_dn && (m_cnt == 255);
        exp_udf  <= m_fire && up_dn && (m_cnt == 0);
        if (m_fire) m_cnt <= up_dn ? (m_cnt + 255) % 256 : (m_cnt + 1) % 256;
        if (!en || m_restart || m_fire) m_phase <= 0;
        else if (!m_halted)             m_phase <= m_phase + 1;
      end
    end
  end

  always @(negedge pclk) begin
    if (presetn) begin
      chk("model_cnt", int'(cnt), m_cnt);
      chk("model_tick", int'(tick), int'(exp_tick));
      chk("model_ovf", int'(ovf_pulse), int'(exp_ovf));
      chk("model_udf", int'(udf_pulse), int'(exp_udf));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  initial begin
    presetn = 1'b0; load = 1'b0; tdr = 8'h00; en = 1'b0; up_dn = 1'b0;
    cks = 2'b00; dbg_halt = 1'b0;
    #1;
    chk("reset_cnt", int'(cnt), 0);
    chk("reset_tick", int'(tick), 0);
    step(2);
    presetn = 1'b1;

    // Overflow: FD -> FE -> FF -> 00 at /2
    load = 1'b1; tdr = 8'hFD;
    step(1);
    chk("t2_load", int'(cnt), 8'hFD);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    step(1); chk("t2_hold", int'(cnt), 8'hFD);
    step(1); chk("t2_fe", int'(cnt), 8'hFE); chk("t2_tick", int'(tick), 1);
    step(2); chk("t2_ff", int'(cnt), 8'hFF); chk("t2_no_ovf", int'(ovf_pulse), 0);
    step(2); chk("t2_00", int'(cnt), 8'h00); chk("t2_ovf", int'(ovf_pulse), 1);
    step(1); chk("t2_ovf_clr", int'(ovf_pulse), 0);

    // Underflow: 02 -> 01 -> 00 -> FF at /16, load coincides with divisor change
    load = 1'b1; tdr = 8'h02; up_dn = 1'b1; cks = 2'b11;
    step(1);
    load = 1'b0;
    step(15); chk("t3_hold", int'(cnt), 8'h02);
    step(1);  chk("t3_01", int'(cnt), 8'h01);
    step(16); chk("t3_00", int'(cnt), 8'h00);
    step(15); chk("t3_pre_ff", int'(cnt), 8'h00); chk("t3_no_udf", int'(udf_pulse), 0);
    step(1);  chk("t3_ff", int'(cnt), 8'hFF); chk("t3_udf", int'(udf_pulse), 1);
    chk("t3_no_ovf", int'(ovf_pulse), 0);
    step(1);  chk("t3_udf_clr", int'(udf_pulse), 0);

    // Collision: load in the cycle of the FF->00 tick
    up_dn = 1'b0;
    step(14);
    load = 1'b1; tdr = 8'h80;
    step(1);
    chk("t4_load", int'(cnt), 8'h80); chk("t4_no_ovf", int'(ovf_pulse), 0);
    chk("t4_no_tick", int'(tick), 0);
    load = 1'b0;
    step(15); chk("t4_hold", int'(cnt), 8'h80);
    step(1);  chk("t4_81", int'(cnt), 8'h81);

    // Divisor switch mid-period restarts the prescaler
    step(5);
    cks = 2'b00;
    step(2); chk("t5_hold", int'(cnt), 8'h81);
    step(1); chk("t5_82", int'(cnt), 8'h82);
    step(1); chk("t5_hold2", int'(cnt), 8'h82);
    step(1); chk("t5_83", int'(cnt), 8'h83);

    // Enable dropped mid-period, then re-enabled: full period
    step(1);
    en = 1'b0;
    step(3); chk("en_hold", int'(cnt), 8'h83);
    en = 1'b1;
    step(1); chk("en_first", int'(cnt), 8'h83);
    step(1); chk("en_84", int'(cnt), 8'h84);

    // Load honoured with counting disabled
    en = 1'b0; load = 1'b1; tdr = 8'h5A;
    step(1); chk("load_en0", int'(cnt), 8'h5A);
    load = 1'b0;
    step(3); chk("load_en0_hold", int'(cnt), 8'h5A);

    // Asynchronous reset mid-count
    en = 1'b1;
    step(3);
    presetn = 1'b0;
    #1;
    chk("t1_cnt", int'(cnt), 0); chk("t1_tick", int'(tick), 0);
    chk("t1_ovf", int'(ovf_pulse), 0); chk("t1_udf", int'(udf_pulse), 0);
    step(1);
    presetn = 1'b1; en = 1'b0;

`ifdef TIMER_HALT_EN
    // Debug halt freezes prescaler and counter
    load = 1'b1; tdr = 8'h10; cks = 2'b01; up_dn = 1'b0;
    step(1);
    load = 1'b0; en = 1'b1;
    step(2);
    dbg_halt = 1'b1;
    step(10); chk("t6_hold", int'(cnt), 8'h10); chk("t6_no_tick", int'(tick), 0);
    dbg_halt = 1'b0;
    step(1); chk("t6_rest", int'(cnt), 8'h10);
    step(1); chk("t6_11", int'(cnt), 8'h11); chk("t6_tick", int'(tick), 1);
`endif

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
